// File: rtl/dmem_lsu_if.sv
// Request/response and data-memory bus bundle for the load/store unit.
// slave: LSU side; master: core/memory side.
interface dmem_lsu_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_we;
  logic [31:0]           i_req_addr;
  logic [1:0]            i_req_size;
  logic                  i_req_unsigned;
  logic [31:0]           i_req_wdata;
  logic                  o_rsp_valid;
  logic [31:0]           o_rsp_rdata;
  logic                  o_rsp_err;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [31:0]           o_mem_wdata;
  logic [3:0]            o_mem_wen;
  logic [31:0]           i_mem_rdata;

  modport slave (
    input  i_req_valid, i_req_we, i_req_addr,
    input  i_req_size, i_req_unsigned, i_req_wdata,
    input  i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata,
    output o_rsp_err, o_mem_addr, o_mem_wdata, o_mem_wen
  );

  modport master (
    output i_req_valid, i_req_we, i_req_addr,
    output i_req_size, i_req_unsigned, i_req_wdata,
    output i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata,
    input  o_rsp_err, o_mem_addr, o_mem_wdata, o_mem_wen
  );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit: lane alignment, boundary split, sign extension.
// Ports: clk, rst_n (async low), bus (dmem_lsu_if.slave).
module dmem_lsu #(
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input logic       clk,
  input logic       rst_n,
  dmem_lsu_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, ACC0, ACC1, WAIT, RESP
  } state_t;

  localparam logic [31:0] LP_DEPTH = 32'(DEPTH);

  state_t r_state, w_next;

  logic                  r_we, r_uns, r_split, r_err;
  logic [1:0]            r_size, r_k;
  logic [ADDR_WIDTH-1:0] r_w;
  logic [31:0]           r_wdata, r_lo, r_rdata;

  function automatic logic [3:0] size_mask(input logic [1:0] s);
    unique case (s)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      2'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  logic        w_acc;
  logic [29:0] w_word;
  logic [7:0]  w_in_lane, w_lane;
  logic        w_in_split, w_in_err;
  logic [63:0] w_d, w_pair;
  logic [31:0] w_sh, w_load;

  assign w_acc      = (r_state == IDLE) & bus.i_req_valid;
  assign w_word     = bus.i_req_addr[31:2];
  assign w_in_lane  = {4'b0, size_mask(bus.i_req_size)}
                      << bus.i_req_addr[1:0];
  assign w_in_split = |w_in_lane[7:4];
  // Second word of a split access must also fit in the memory.
  assign w_in_err   = (bus.i_req_size == 2'd3)
                    | ({2'b0, w_word} >= LP_DEPTH)
                    | (w_in_split &
                       (({2'b0, w_word} + 32'd1) >= LP_DEPTH));

  assign w_lane = {4'b0, size_mask(r_size)} << r_k;
  assign w_d    = {32'b0, r_wdata} << {r_k, 3'b000};

  // Split loads join the captured low word with the high word.
  assign w_pair = r_split ? {bus.i_mem_rdata, r_lo}
                          : {32'b0, bus.i_mem_rdata};
  assign w_sh   = 32'(w_pair >> {r_k, 3'b000});

  always_comb begin
    w_load = w_sh;
    unique case (r_size)
      2'd0:
        w_load = {{24{~r_uns & w_sh[7]}}, w_sh[7:0]};
      2'd1:
        w_load = {{16{~r_uns & w_sh[15]}}, w_sh[15:0]};
      default:
        w_load = w_sh;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (bus.i_req_valid)
          w_next = w_in_err ? RESP : ACC0;
      ACC0:    w_next = r_split ? ACC1 : WAIT;
      ACC1:    w_next = WAIT;
      WAIT:    w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_split <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= 2'd0;
      r_k     <= 2'd0;
      r_w     <= '0;
      r_wdata <= 32'd0;
      r_lo    <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      if (w_acc) begin
        r_we    <= bus.i_req_we;
        r_uns   <= bus.i_req_unsigned;
        r_size  <= bus.i_req_size;
        r_k     <= bus.i_req_addr[1:0];
        r_wdata <= bus.i_req_wdata;
        r_split <= w_in_split;
        r_err   <= w_in_err;
        r_w     <= w_in_err ? '0
                 : bus.i_req_addr[ADDR_WIDTH+1:2];
        r_rdata <= 32'd0;
      end
      if (r_state == ACC1)
        r_lo <= bus.i_mem_rdata;
      if (r_state == WAIT)
        r_rdata <= r_we ? 32'd0 : w_load;
      if (r_state == RESP) begin
        r_rdata <= 32'd0;
        r_err   <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = 32'd0;
    bus.o_mem_wen   = 4'd0;
    unique case (r_state)
      ACC0: begin
        bus.o_mem_addr  = r_w;
        bus.o_mem_wdata = w_d[31:0];
        bus.o_mem_wen   = r_we ? w_lane[3:0] : 4'd0;
      end
      ACC1: begin
        bus.o_mem_addr  = r_w + ADDR_WIDTH'(1);
        bus.o_mem_wdata = w_d[63:32];
        bus.o_mem_wen   = r_we ? w_lane[7:4] : 4'd0;
      end
      default: ;
    endcase
  end

  assign bus.o_req_ready = (r_state == IDLE);
  assign bus.o_rsp_valid = (r_state == RESP);
  assign bus.o_rsp_rdata = r_rdata;
  assign bus.o_rsp_err   = r_err;
endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu with byte-level memory reference.
// Drives requests, models memory, checks responses and bus activity.
module tb_dmem_lsu;
  localparam int DEPTH = 2048;
  localparam int AW    = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_lsu_if #(.ADDR_WIDTH(AW)) bus();

  dmem_lsu #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [7:0]  ref_mem [0:DEPTH*4-1];
  logic [31:0] pmem    [0:DEPTH-1];
  logic [31:0] mw;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous write-first memory.
  always @(posedge clk) begin
    mw = pmem[bus.o_mem_addr];
    for (int b = 0; b < 4; b++)
      if (bus.o_mem_wen[b]) mw[8*b +: 8] = bus.o_mem_wdata[8*b +: 8];
    pmem[bus.o_mem_addr] <= mw;
    bus.i_mem_rdata      <= mw;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: byte-addressed little-endian memory.
  task automatic model(input logic we, input logic [31:0] addr,
                       input logic [1:0] sz, input logic uns,
                       input logic [31:0] wd,
                       output logic [31:0] rd, output logic err,
                       output int lat);
    int          n;
    longint      last;
    logic [31:0] v;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    last = longint'(addr) + n - 1;
    err  = (sz == 2'd3) || (last >= longint'(DEPTH * 4));
    rd   = 32'd0;
    lat  = 0;
    if (err) return;
    lat = ((int'(addr % 4) + n) > 4) ? 3 : 2;
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[addr + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[addr + i];
      if (!uns && v[8*n-1])
        for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      rd = v;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.o_rsp_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_rdata", bus.o_rsp_rdata, e.rd);
        chk("rsp_err", 32'(bus.o_rsp_err), 32'(e.err));
        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [1:0] sz, input logic uns,
                       input logic [31:0] wd, input bit track);
    int   n;
    exp_t e;
    int   lat;
    bus.i_req_we       = we;
    bus.i_req_addr     = addr;
    bus.i_req_size     = sz;
    bus.i_req_unsigned = uns;
    bus.i_req_wdata    = wd;
    bus.i_req_valid    = 1'b1;
    n = 0;
    while (!bus.o_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_req_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      bus.i_req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    chk("ready_low_after_accept", 32'(bus.o_req_ready), 32'd0);
    if (!track) return;
    model(we, addr, sz, uns, wd, e.rd, e.err, lat);
    e.cyc = cyc + lat;
    sb_q.push_back(e);
    if (e.err) chk("err_no_wen", 32'(bus.o_mem_wen), 32'd0);
  endtask

  task automatic drain();
    int n;
    bus.i_req_valid = 1'b0;
    n = 0;
    while ((sb_q.size() != 0 || !bus.o_req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_bus(input string nm, input logic [31:0] a,
                         input logic [3:0] w, input logic [31:0] d);
    chk({nm, "_addr"}, 32'(bus.o_mem_addr), a);
    chk({nm, "_wen"}, 32'(bus.o_mem_wen), 32'(w));
    chk({nm, "_wdata"}, bus.o_mem_wdata, d);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w81;
    logic [31:0] addr;
    logic [1:0]  sz;
    int          r;
    bus.i_req_valid    = 1'b0;
    bus.i_req_we       = 1'b0;
    bus.i_req_addr     = 32'd0;
    bus.i_req_size     = 2'd0;
    bus.i_req_unsigned = 1'b0;
    bus.i_req_wdata    = 32'd0;
    for (int i = 0; i < DEPTH * 4; i++) ref_mem[i] = 8'($urandom);
    for (int i = 0; i < DEPTH; i++)
      pmem[i] = {ref_mem[4*i+3], ref_mem[4*i+2],
                 ref_mem[4*i+1], ref_mem[4*i]};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.o_req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("rst_rdata", bus.o_rsp_rdata, 32'd0);
    chk("rst_err", 32'(bus.o_rsp_err), 32'd0);
    chk_bus("rst", 32'd0, 4'd0, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(1'b1, 32'h100, 2'd2, 1'b0, 32'hDEADBEEF, 1'b1);
    chk_bus("sw_acc0", 32'h40, 4'b1111, 32'hDEADBEEF);
    drain();
    issue(1'b0, 32'h101, 2'd0, 1'b0, 32'd0, 1'b1);
    drain();
    issue(1'b0, 32'h101, 2'd0, 1'b1, 32'd0, 1'b1);
    drain();
    issue(1'b0, 32'h102, 2'd1, 1'b0, 32'd0, 1'b1);
    drain();

    issue(1'b1, 32'h203, 2'd1, 1'b0, 32'h0000A55A, 1'b1);
    chk_bus("sh_acc0", 32'h80, 4'b1000, 32'h5A000000);
    @(posedge clk);
    #1;
    chk_bus("sh_acc1", 32'h81, 4'b0001, 32'h000000A5);
    drain();
    issue(1'b0, 32'h203, 2'd1, 1'b0, 32'd0, 1'b1);
    drain();

    issue(1'b0, 32'h2000, 2'd2, 1'b0, 32'd0, 1'b1);
    drain();
    issue(1'b1, 32'h1FFD, 2'd2, 1'b0, 32'h12345678, 1'b1);
    drain();
    issue(1'b0, 32'h10, 2'd3, 1'b0, 32'd0, 1'b1);
    drain();

    // Reset during the second half of a split store.
    w81 = pmem[32'h81];
    issue(1'b1, 32'h203, 2'd1, 1'b0, 32'h00001234, 1'b0);
    bus.i_req_valid = 1'b0;
    chk_bus("rst_acc0", 32'h80, 4'b1000, 32'h34000000);
    @(posedge clk);
    #1;
    chk("rst_acc1_wen", 32'(bus.o_mem_wen), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_wen", 32'(bus.o_mem_wen), 32'd0);
    chk("async_ready", 32'(bus.o_req_ready), 32'd1);
    chk("async_rsp", 32'(bus.o_rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ref_mem[32'h203] = 8'h34;
    chk("word81_kept", pmem[32'h81], w81);
    issue(1'b0, 32'h200, 2'd2, 1'b0, 32'd0, 1'b1);
    drain();
    issue(1'b0, 32'h204, 2'd2, 1'b0, 32'd0, 1'b1);
    drain();

    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      addr = 32'($urandom_range(0, 127));
      else if (r < 9) addr = 32'h1FF0 + 32'($urandom_range(0, 31));
      else            addr = $urandom;
      r  = $urandom_range(0, 9);
      sz = (r == 9) ? 2'd3 : 2'(r % 3);
      issue(1'($urandom), addr, sz, 1'($urandom), $urandom, 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        bus.i_req_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    drain();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
